// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle RV32I control unit.
//   state_t        - controller FSM states
//   OP_*           - supported opcodes (instr[6:0])
//   ALU_*, ALUOP_* - ALU function codes and the internal ALUOp field
//   RES_*, SRCA_*, SRCB_*, IMM_* - datapath mux select encodings
//   imm_src()      - immediate format selected from the opcode
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath bundle.
//   datapath -> controller : op, funct3, funct7b5, Zero
//   controller -> datapath : enables (PCWrite, MemWrite, IRWrite, RegWrite),
//                            mux selects, ImmSrc, ALUControl,
//                            status pulses illegal_instr / instr_retired
//   master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       illegal_instr;
  logic       instr_retired;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal_instr, instr_retired
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, illegal_instr, instr_retired
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: combinational ALU function select.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3, 11 add
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], distinguishes R-type from I-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU function code
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has no funct7, so instr[30] only means sub for R-type
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for lw, sw, R-type, I-type, beq, jal.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      mc_controller_if.master: instruction fields and Zero in,
//            write enables, mux selects, ALUControl and status pulses out
//
// state      | meaning
// S_FETCH    | read instr at PC, PC <= PC+4
// S_DECODE   | compute branch target, dispatch on opcode
// S_MEMADR   | rs1 + imm address for lw/sw
// S_MEMREAD  | read data memory
// S_MEMWB    | write loaded data to rd
// S_MEMWRITE | write rs2 to data memory
// S_EXECUTER | register-register ALU op
// S_EXECUTEI | register-immediate ALU op
// S_ALUWB    | write ALU result to rd
// S_BEQ      | compare rs1/rs2, take branch on Zero
// S_JAL      | PC <= target, OldPC+4 computed for rd
module mc_controller
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mc_controller_if.master   bus
);

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write, illegal, retired;
  logic       adr_src;
  logic [1:0] result_src, src_a, src_b, alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    retired    = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_REGA;
        src_b   = SRCB_IMM;
        state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retired    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECUTER: begin
        src_a   = SRCA_REGA;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        src_a   = SRCA_REGA;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a   = SRCA_REGA;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retired = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables and pulses are gated by reset_n directly so nothing can write
  // while reset is held, even though the state register already sits in FETCH.
  assign bus.PCWrite       = reset_n & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite       = reset_n & ir_write;
  assign bus.RegWrite      = reset_n & reg_write;
  assign bus.MemWrite      = reset_n & mem_write;
  assign bus.illegal_instr = reset_n & illegal;
  assign bus.instr_retired = reset_n & retired;
  assign bus.AdrSrc        = adr_src;
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = src_a;
  assign bus.ALUSrcB       = src_b;
  assign bus.ImmSrc        = imm_src(bus.op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.ALUControl)
  );

endmodule
